// File: rtl/corr_pkg.sv
// Shared types and helpers for the correlator lag scanner.
package corr_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_RES_W = 4;
  localparam int DEF_LAG_W = 3;
  // rotl() works on a fixed container; operands wider than this are not supported
  localparam int ROT_MAX_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRST,
    S_WAIT,
    S_CAPT,
    S_DONE
  } state_t;

  // Rotate the low w bits of x left by k (k < w); bits above w are returned as 0.
  function automatic logic [ROT_MAX_W-1:0] rotl(input logic [ROT_MAX_W-1:0] x,
                                                input int w, input int k);
    logic [ROT_MAX_W-1:0] y;
    int j;
    y = '0;
    for (int i = 0; i < ROT_MAX_W; i++) begin
      if (i < w) begin
        j = i + k;
        if (j >= w) j = j - w;
        y[j] = x[i];
      end
    end
    return y;
  endfunction

endpackage

// File: rtl/corr_lag_scanner.sv
// Sequences an external bit-match correlator over all WIDTH rotations of the
// probe word, streaming each lag's score and reporting the peak and its lag.
module corr_lag_scanner
  import corr_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int RES_W    = DEF_RES_W,
  parameter int LAG_W    = DEF_LAG_W,
  parameter int CORR_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] ref_word,
  input  logic [WIDTH-1:0] probe_word,
  output logic [WIDTH-1:0] corr_signal1,
  output logic [WIDTH-1:0] corr_signal2,
  output logic             corr_reset,
  input  logic [RES_W-1:0] corr_result,
  output logic             busy,
  output logic             lag_valid,
  output logic [LAG_W-1:0] lag_idx,
  output logic [RES_W-1:0] lag_score,
  output logic             done,
  output logic [RES_W-1:0] best_score,
  output logic [LAG_W-1:0] best_lag
);

  localparam int               CNT_W    = $clog2(CORR_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CORR_LAT - 1);
  localparam logic [LAG_W-1:0] LAST_LAG = LAG_W'(WIDTH - 1);

  state_t           r_state, w_nxt;
  logic [WIDTH-1:0] r_ref, r_prb;
  logic [LAG_W-1:0] r_lag, r_run_lag, r_lag_idx, r_best_lag;
  logic [RES_W-1:0] r_run_best, r_lag_score, r_best_score;
  logic [CNT_W-1:0] r_cnt;
  logic             r_lag_valid, r_done;
  logic             w_accept;

  assign w_accept = (r_state == S_IDLE) && start && !abort;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_nxt = S_CRST;
      S_CRST:  w_nxt = S_WAIT;
      S_WAIT:  if (r_cnt == '0) w_nxt = S_CAPT;
      S_CAPT:  w_nxt = (r_lag == LAST_LAG) ? S_DONE : S_CRST;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
    // abort in IDLE already blocks w_accept, so forcing IDLE is safe everywhere
    if (abort) w_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ref        <= '0;
      r_prb        <= '0;
      r_lag        <= '0;
      r_cnt        <= '0;
      r_run_best   <= '0;
      r_run_lag    <= '0;
      r_lag_idx    <= '0;
      r_lag_score  <= '0;
      r_lag_valid  <= 1'b0;
      r_best_score <= '0;
      r_best_lag   <= '0;
      r_done       <= 1'b0;
    end else begin
      r_lag_valid <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_ref      <= ref_word;
          r_prb      <= probe_word;
          r_lag      <= '0;
          r_run_best <= '0;
          r_run_lag  <= '0;
        end
        S_CRST: r_cnt <= CNT_LOAD;
        S_WAIT: if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        S_CAPT: if (!abort) begin
          r_lag_score <= corr_result;
          r_lag_idx   <= r_lag;
          r_lag_valid <= 1'b1;
          // strict compare: on a tie the earlier (lower) lag is kept
          if (corr_result > r_run_best) begin
            r_run_best <= corr_result;
            r_run_lag  <= r_lag;
          end
          if (r_lag != LAST_LAG) r_lag <= r_lag + 1'b1;
        end
        S_DONE: if (!abort) begin
          r_best_score <= r_run_best;
          r_best_lag   <= r_run_lag;
          r_done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign corr_signal1 = r_ref;
  assign corr_signal2 = WIDTH'(rotl(ROT_MAX_W'(r_prb), WIDTH, int'(r_lag)));
  assign corr_reset   = (r_state == S_CRST);
  assign busy         = (r_state != S_IDLE);
  assign lag_valid    = r_lag_valid;
  assign lag_idx      = r_lag_idx;
  assign lag_score    = r_lag_score;
  assign done         = r_done;
  assign best_score   = r_best_score;
  assign best_lag     = r_best_lag;

endmodule

// File: tb/tb_corr_lag_scanner.sv
// Directed bench: three scanners (CORR_LAT 1, 2, 5) share stimulus, each paired
// with a behavioural correlator; instance 1 (CORR_LAT=2) is the primary target.
module tb_corr_lag_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] ref_word = '0;
  logic [7:0] probe_word = '0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         t0 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 2 : 5;
    logic       busy, lag_valid, done, corr_reset;
    logic [7:0] s1, s2;
    logic [3:0] res, lag_score, best_score;
    logic [2:0] lag_idx, best_lag;
    int         mcnt = 0;
    int         n_crst = 0, n_lagv = 0, n_done = 0, done_cyc = 0;
    logic [3:0] sc_log[256];
    logic [2:0] ix_log[256];
    int         lv_cyc[256];

    corr_lag_scanner #(.WIDTH(8), .RES_W(4), .LAG_W(3), .CORR_LAT(LAT)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .ref_word(ref_word), .probe_word(probe_word),
      .corr_signal1(s1), .corr_signal2(s2), .corr_reset(corr_reset),
      .corr_result(res), .busy(busy), .lag_valid(lag_valid),
      .lag_idx(lag_idx), .lag_score(lag_score), .done(done),
      .best_score(best_score), .best_lag(best_lag)
    );

    // Correlator model: garbage (15) until LAT cycles after its reset pulse.
    always @(posedge clk) begin
      if (corr_reset) mcnt <= LAT;
      else if (mcnt > 0) mcnt <= mcnt - 1;
    end
    assign res = (mcnt == 0) ? 4'($countones(~(s1 ^ s2))) : 4'hF;

    always @(negedge clk) begin
      if (!reset) begin
        if (corr_reset) n_crst <= n_crst + 1;
        if (lag_valid) begin
          sc_log[n_lagv % 256] <= lag_score;
          ix_log[n_lagv % 256] <= lag_idx;
          lv_cyc[n_lagv % 256] <= cyc;
          n_lagv <= n_lagv + 1;
        end
        if (done) begin
          n_done   <= n_done + 1;
          done_cyc <= cyc;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; t0 is the cycle whose closing edge accepts start.
  task automatic do_start(input logic [7:0] r, input logic [7:0] p);
    ref_word = r; probe_word = p; start = 1'b1; t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int b0, input int b1, input int b2);
    int n = 0;
    while ((gi[0].n_done == b0 || gi[1].n_done == b1 || gi[2].n_done == b2) && n < 150) begin
      @(negedge clk);
      n++;
    end
    chk("scan_timeout", 32'(n < 150), 1);
  endtask

  task automatic wait_until(input int c);
    int n = 0;
    while (cyc != c && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_cycle", cyc, c);
  endtask

  int e1[8] = '{8, 4, 4, 2, 4, 2, 4, 4};  // ref=probe=10001011
  int e2[8] = '{2, 4, 4, 8, 4, 4, 2, 4};  // probe = ref rotated right by 3
  int b0, b1, b2, lb, lb0, lb2, c1, c2;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", gi[1].busy, 0);
    chk("rst_corr_reset", gi[1].corr_reset, 0);
    chk("rst_sig1", gi[1].s1, 0);
    chk("rst_sig2", gi[1].s2, 0);
    chk("rst_lag_valid", gi[1].lag_valid, 0);
    chk("rst_done", gi[1].done, 0);
    chk("rst_best_score", gi[1].best_score, 0);
    chk("rst_best_lag", gi[1].best_lag, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: identical operands, plus latency/corr_reset count across CORR_LAT 1/2/5
    b0 = gi[0].n_done; b1 = gi[1].n_done; b2 = gi[2].n_done;
    lb = gi[1].n_lagv; lb0 = gi[0].n_lagv; lb2 = gi[2].n_lagv;
    c1 = gi[1].n_crst;
    do_start(8'b10001011, 8'b10001011);
    chk("s1_busy", gi[1].busy, 1);
    wait_done(b0, b1, b2);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      chk("s1_idx", gi[1].ix_log[(lb + k) % 256], k);
      chk("s1_score", gi[1].sc_log[(lb + k) % 256], e1[k]);
    end
    chk("s1_lv0_time", gi[1].lv_cyc[lb % 256] - t0, 5);
    chk("s1_lv7_time", gi[1].lv_cyc[(lb + 7) % 256] - t0, 33);
    chk("s1_done_lat2", gi[1].done_cyc - t0, 34);
    chk("s1_done_lat1", gi[0].done_cyc - t0, 26);
    chk("s1_done_lat5", gi[2].done_cyc - t0, 58);
    chk("s1_crst_cnt", gi[1].n_crst - c1, 8);
    chk("s1_lat1_score3", gi[0].sc_log[(lb0 + 3) % 256], 2);
    chk("s1_lat5_score0", gi[2].sc_log[lb2 % 256], 8);
    chk("s1_best_score", gi[1].best_score, 8);
    chk("s1_best_lag", gi[1].best_lag, 0);
    chk("s1_idle", gi[1].busy, 0);

    // 2: probe is ref rotated right by 3 -> peak at lag 3
    b0 = gi[0].n_done; b1 = gi[1].n_done; b2 = gi[2].n_done;
    lb = gi[1].n_lagv;
    do_start(8'b10001011, 8'b01110001);
    wait_done(b0, b1, b2);
    @(negedge clk);
    chk("s2_lv_count", gi[1].n_lagv - lb, 8);
    for (int k = 0; k < 8; k++) begin
      chk("s2_idx", gi[1].ix_log[(lb + k) % 256], k);
      chk("s2_score", gi[1].sc_log[(lb + k) % 256], e2[k]);
    end
    chk("s2_best_score", gi[1].best_score, 8);
    chk("s2_best_lag", gi[1].best_lag, 3);

    // 4: abort in lag-4 WAIT
    b1 = gi[1].n_done; lb = gi[1].n_lagv;
    do_start(8'h0F, 8'h81);
    wait_until(t0 + 17);
    chk("ab_crst_lag4", gi[1].corr_reset, 1);
    chk("ab_sig1", gi[1].s1, 8'h0F);
    chk("ab_sig2_rot4", gi[1].s2, 8'h18);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy_drop", gi[1].busy, 0);
    repeat (40) @(negedge clk);
    chk("ab_no_done", gi[1].n_done - b1, 0);
    chk("ab_lv_count", gi[1].n_lagv - lb, 4);
    chk("ab_best_score", gi[1].best_score, 8);
    chk("ab_best_lag", gi[1].best_lag, 3);

    // abort together with start in IDLE is not accepted
    abort = 1'b1;
    do_start(8'h00, 8'h00);
    abort = 1'b0;
    chk("ab_start_blocked", gi[1].busy, 0);

    // 3: all-mismatch then all-match (tie rule keeps lag 0)
    b0 = gi[0].n_done; b1 = gi[1].n_done; b2 = gi[2].n_done;
    lb = gi[1].n_lagv;
    do_start(8'hFF, 8'h00);
    wait_done(b0, b1, b2);
    @(negedge clk);
    chk("s3a_score5", gi[1].sc_log[(lb + 5) % 256], 0);
    chk("s3a_best_score", gi[1].best_score, 0);
    chk("s3a_best_lag", gi[1].best_lag, 0);
    b0 = gi[0].n_done; b1 = gi[1].n_done; b2 = gi[2].n_done;
    lb = gi[1].n_lagv;
    do_start(8'h00, 8'h00);
    wait_done(b0, b1, b2);
    @(negedge clk);
    chk("s3b_score7", gi[1].sc_log[(lb + 7) % 256], 8);
    chk("s3b_best_score", gi[1].best_score, 8);
    chk("s3b_best_lag", gi[1].best_lag, 0);

    // 5: operand changes and a second start mid-scan are ignored
    b0 = gi[0].n_done; b1 = gi[1].n_done; b2 = gi[2].n_done;
    lb = gi[1].n_lagv;
    do_start(8'b10001011, 8'b10001011);
    c2 = t0;
    wait_until(t0 + 10);
    ref_word = 8'h55; probe_word = 8'hAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = c2;
    wait_done(b0, b1, b2);
    repeat (40) @(negedge clk);
    for (int k = 0; k < 8; k++)
      chk("s5_score", gi[1].sc_log[(lb + k) % 256], e1[k]);
    chk("s5_one_done", gi[1].n_done - b1, 1);
    chk("s5_one_done_lat5", gi[2].n_done - b2, 1);
    chk("s5_done_lat", gi[1].done_cyc - t0, 34);
    chk("s5_best_lag", gi[1].best_lag, 0);

    // reset mid-scan clears everything, including best_*
    do_start(8'h3C, 8'h0F);
    wait_until(t0 + 12);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_busy", gi[1].busy, 0);
    chk("mr_corr_reset", gi[1].corr_reset, 0);
    chk("mr_sig1", gi[1].s1, 0);
    chk("mr_sig2", gi[1].s2, 0);
    chk("mr_lag_valid", gi[1].lag_valid, 0);
    chk("mr_lag_idx", gi[1].lag_idx, 0);
    chk("mr_lag_score", gi[1].lag_score, 0);
    chk("mr_done", gi[1].done, 0);
    chk("mr_best_score", gi[1].best_score, 0);
    chk("mr_best_lag", gi[1].best_lag, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
